// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line and consumer acknowledge in, received word and status flags out.
// The master modport drives RX/clr_rdy; the slave modport is the receiver.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 RX;
    logic                 clr_rdy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rdy;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  parity_err,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output parity_err,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (baud divisor, 5..9 data bits, none/odd/even parity) with error flags.
// rdy rises 3 + BAUD_DIV/2 + frame_bits*BAUD_DIV clk after the start edge; no backpressure, a busy consumer only raises overrun.
module uart_rx_cfg #(
    parameter int BAUD_DIV  = 2604,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_cfg_if.slave  bus
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic                 rx_meta;
    logic                 rxs;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 armed;
    logic                 expiry;

    assign expiry = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.RX;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
            armed          <= 1'b0;
            bus.rx_data    <= '0;
            bus.rdy        <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (bus.clr_rdy) begin
                bus.rdy     <= 1'b0;
                bus.overrun <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    // armed blocks a held-low line (break) from re-triggering until it goes high
                    if (rxs) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        cnt   <= HALF_LOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (!expiry) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= S_IDLE;
                    end else begin
                        cnt     <= FULL_LOAD;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!expiry) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        cnt     <= FULL_LOAD;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end
                    end
                end
                S_PAR: begin
                    if (!expiry) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_bit <= rxs;
                        cnt     <= FULL_LOAD;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!expiry) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // completion overrides a coincident clr_rdy: the set wins
                        bus.rx_data    <= shreg;
                        bus.frame_err  <= ~rxs;
                        bus.parity_err <= (PARITY != 0) && ((^shreg ^ par_bit) != (PARITY == 1));
                        bus.rdy        <= 1'b1;
                        bus.overrun    <= bus.rdy & ~bus.clr_rdy;
                        armed          <= rxs;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
